// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU ops, writeback select.
// Used by every block of the single-cycle core.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_EBREAK = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_IMM
  } wb_sel_e;

  function automatic alu_op_e alu_op_of(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu_if.sv
// ALU operand/result bundle between the core datapath and rv32i_alu.
// master drives operands, slave returns result and compare flags.
interface rv32i_alu_if;
  import rv32i_pkg::*;

  logic [31:0] a;
  logic [31:0] b;
  alu_op_e     op;
  logic [31:0] y;
  logic        zero;
  logic        lt;
  logic        ltu;

  modport master (
    output a, b, op,
    input  y, zero, lt, ltu
  );

  modport slave (
    input  a, b, op,
    output y, zero, lt, ltu
  );

endinterface

// File: rtl/rv32i_alu.sv
// RV32I integer ALU with branch compare flags.
// zero reflects y, lt/ltu compare the raw operands.
import rv32i_pkg::*;

module rv32i_alu (
  rv32i_alu_if.slave bus
);

  logic [4:0] sh;

  assign sh = bus.b[4:0];

  always_comb begin
    bus.y = '0;
    unique case (bus.op)
      ALU_ADD:   bus.y = bus.a + bus.b;
      ALU_SUB:   bus.y = bus.a - bus.b;
      ALU_SLL:   bus.y = bus.a << sh;
      ALU_SLT:   bus.y = {31'b0, bus.lt};
      ALU_SLTU:  bus.y = {31'b0, bus.ltu};
      ALU_XOR:   bus.y = bus.a ^ bus.b;
      ALU_SRL:   bus.y = bus.a >> sh;
      ALU_SRA:   bus.y = $unsigned($signed(bus.a) >>> sh);
      ALU_OR:    bus.y = bus.a | bus.b;
      ALU_AND:   bus.y = bus.a & bus.b;
      ALU_PASSB: bus.y = bus.b;
      default:   bus.y = '0;
    endcase
  end

  assign bus.zero = (bus.y == 32'd0);
  assign bus.lt   = $signed(bus.a) < $signed(bus.b);
  assign bus.ltu  = bus.a < bus.b;

endmodule

// File: rtl/risc_v_processor.sv
// Single-cycle RV32I core with internal ROM/RAM; wb_data exposes writeback.
// Optional HALT_ON_EBREAK_EN: EBREAK freezes the core until reset.
import rv32i_pkg::*;

module risc_v_processor #(
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256,
  parameter string IMEM_INIT  = "program.mem"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] wb_data
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf [32];

  logic [31:0] pc, pc4, npc, insn;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        a_pc, b_imm, reg_write, mem_write;
  logic        is_br, is_jal, is_jalr, take, stall;
  logic [31:0] word, load_v, wb_val;
  logic [31:0] st_data;
  logic [3:0]  st_be;

  rv32i_alu_if alu_bus ();
  rv32i_alu u_alu (.bus(alu_bus));

  assign insn   = imem[pc[IAW+1:2]];
  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign f3     = insn[14:12];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign rs1_v  = rf[rs1];
  assign rs2_v  = rf[rs2];

  assign imm_i = {{20{insn[31]}}, insn[31:20]};
  assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b = {{19{insn[31]}}, insn[31], insn[7],
                  insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'b0};
  assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12],
                  insn[20], insn[30:21], 1'b0};

  always_comb begin
    imm       = '0;
    alu_op    = ALU_ADD;
    a_pc      = 1'b0;
    b_imm     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    wb_sel    = WB_ALU;
    is_br     = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    unique case (1'b1)
      opcode == OP_LUI: begin
        imm = imm_u; reg_write = 1'b1; wb_sel = WB_IMM;
      end
      opcode == OP_AUIPC: begin
        imm = imm_u; a_pc = 1'b1; b_imm = 1'b1;
        reg_write = 1'b1;
      end
      opcode == OP_JAL: begin
        imm = imm_j; is_jal = 1'b1;
        reg_write = 1'b1; wb_sel = WB_PC4;
      end
      opcode == OP_JALR: begin
        imm = imm_i; b_imm = 1'b1; is_jalr = 1'b1;
        reg_write = 1'b1; wb_sel = WB_PC4;
      end
      opcode == OP_BRANCH: begin
        imm = imm_b; alu_op = ALU_SUB; is_br = 1'b1;
      end
      opcode == OP_LOAD: begin
        imm = imm_i; b_imm = 1'b1;
        reg_write = 1'b1; wb_sel = WB_MEM;
      end
      opcode == OP_STORE: begin
        imm = imm_s; b_imm = 1'b1; mem_write = 1'b1;
      end
      opcode == OP_IMM: begin
        imm = imm_i; b_imm = 1'b1; reg_write = 1'b1;
        // ADDI has no SUB form; bit 30 only selects SRAI
        alu_op = alu_op_of(f3, (f3 == 3'd5) & insn[30]);
      end
      opcode == OP_REG: begin
        reg_write = 1'b1;
        alu_op = alu_op_of(f3, insn[30]);
      end
      default: ;
    endcase
  end

  assign alu_bus.a  = a_pc ? pc : rs1_v;
  assign alu_bus.b  = b_imm ? imm : rs2_v;
  assign alu_bus.op = alu_op;

  always_comb begin
    case (f3)
      3'b000:  take = alu_bus.zero;
      3'b001:  take = ~alu_bus.zero;
      3'b100:  take = alu_bus.lt;
      3'b101:  take = ~alu_bus.lt;
      3'b110:  take = alu_bus.ltu;
      3'b111:  take = ~alu_bus.ltu;
      default: take = 1'b0;
    endcase
  end

  assign pc4 = pc + 32'd4;
  assign npc = is_jalr ? (alu_bus.y & ~32'd1) :
               (is_jal | (is_br & take)) ? pc + imm : pc4;

  assign word = dmem[alu_bus.y[DAW+1:2]];

  always_comb begin
    case (f3)
      3'b000:  load_v = {{24{word[{alu_bus.y[1:0], 3'b111}]}},
                         word[{alu_bus.y[1:0], 3'b000} +: 8]};
      3'b001:  load_v = {{16{word[{alu_bus.y[1], 4'hf}]}},
                         word[{alu_bus.y[1], 4'h0} +: 16]};
      3'b100:  load_v = {24'b0, word[{alu_bus.y[1:0], 3'b000} +: 8]};
      3'b101:  load_v = {16'b0, word[{alu_bus.y[1], 4'h0} +: 16]};
      default: load_v = word;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        st_data = {4{rs2_v[7:0]}};
        st_be   = 4'b0001 << alu_bus.y[1:0];
      end
      2'b01: begin
        st_data = {2{rs2_v[15:0]}};
        st_be   = alu_bus.y[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = rs2_v;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    unique case (wb_sel)
      WB_ALU: wb_val = alu_bus.y;
      WB_MEM: wb_val = load_v;
      WB_PC4: wb_val = pc4;
      WB_IMM: wb_val = imm;
    endcase
  end

`ifdef HALT_ON_EBREAK_EN
  logic halted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halted <= 1'b0;
    else if (insn == INSN_EBREAK) halted <= 1'b1;
  end

  assign stall = halted | (insn == INSN_EBREAK);
`else
  assign stall = 1'b0;
`endif

  assign wb_data = (reset && reg_write && !stall) ? wb_val : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!stall) begin
      pc <= npc;
      if (reg_write && rd != 5'd0) rf[rd] <= wb_val;
    end
  end

  // data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (reset && mem_write && !stall) begin
      for (int i = 0; i < 4; i++)
        if (st_be[i])
          dmem[alu_bus.y[DAW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_risc_v_processor.sv
// Directed program test for risc_v_processor; ROM preloaded by the bench.
// Define HALT_ON_EBREAK_EN to expect halting behaviour after EBREAK.
module tb_risc_v_processor;

  logic        clk;
  logic        reset;
  logic [31:0] wb_data;
  int          total;
  int          bad;

  localparam int NPROG = 33;
  localparam logic [31:0] PROG [NPROG] = '{
    32'h00500093, 32'hFFF00113, 32'h01C15193, 32'h41C15213,
    32'h123452B7, 32'h67828293, 32'h00502023, 32'h00000303,
    32'h008000EF, 32'h06300493, 32'h00304383, 32'h00000463,
    32'h04D00493, 32'h00700013, 32'h00000433, 32'h405084B3,
    32'h00112533, 32'h001135B3, 32'h00201323, 32'h00601603,
    32'h00605683, 32'h00202703, 32'h00001463, 32'h00014463,
    32'h00100793, 32'h00001797, 32'h05108867, 32'h00100893,
    32'h00200893, 32'h00100073, 32'h05500993, 32'h00F9CA13,
    32'h00299AB3
  };

  risc_v_processor #(
    .IMEM_WORDS(256),
    .DMEM_WORDS(256),
    .IMEM_INIT ("")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wb_data(wb_data)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] exp);
    chk(tag, wb_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i < NPROG) dut.imem[i] = PROG[i];
      else dut.imem[i] = 32'h0;
    end
    #6;
    chk("reset_wb", wb_data, 32'h0);
    #9 reset = 1'b1;
    #1;
    step("addi_x1",   32'h00000005);
    step("addi_m1",   32'hFFFFFFFF);
    step("srli",      32'h0000000F);
    step("srai",      32'hFFFFFFFF);
    step("lui",       32'h12345000);
    step("addi_x5",   32'h12345678);
    step("sw",        32'h00000000);
    step("lb",        32'h00000078);
    step("jal",       32'h00000024);
    step("lbu",       32'h00000012);
    step("beq",       32'h00000000);
    step("addi_x0",   32'h00000007);
    step("add_x0",    32'h00000000);
    step("sub",       32'hEDCBA9AC);
    step("slt",       32'h00000001);
    step("sltu",      32'h00000000);
    step("sh",        32'h00000000);
    step("lh",        32'hFFFFFFFF);
    step("lhu",       32'h0000FFFF);
    step("lw_misal",  32'h12345678);
    step("bne_nt",    32'h00000000);
    step("blt_t",     32'h00000000);
    step("auipc",     32'h00001064);
    step("jalr",      32'h0000006C);
    step("ebreak",    32'h00000000);
`ifdef HALT_ON_EBREAK_EN
    step("halt_1",    32'h00000000);
    step("halt_2",    32'h00000000);
    step("halt_3",    32'h00000000);
`else
    step("addi_x19",  32'h00000055);
    step("xori",      32'h0000005A);
    step("sll_31",    32'h80000000);
`endif
    #2 reset = 1'b0;
    #1;
    chk("rst_async", wb_data, 32'h0);
    chk("rst_x5", dut.rf[5], 32'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    step("restart_0", 32'h00000005);
    step("restart_1", 32'hFFFFFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
